// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART stream controller.
// Holds the controller FSM states, the RX/TX slot selector and the UART register layout.
package uart_ctrl_pkg;

    typedef enum logic [3:0] {
        INIT_S,
        INIT_A,
        IDLE,
        CFG_S,
        CFG_A,
        TXS_S,
        TXS_A,
        TXW_S,
        TXW_A,
        RXR_S,
        RXR_A
    } ctrl_state_e;

    typedef enum logic {
        SLOT_RX,
        SLOT_TX
    } slot_e;

    localparam int          UART_EMPTY_BIT  = 31;
    localparam logic [15:0] DEFAULT_DIVISOR = 16'd434;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after last_grant, wrapping.
// Returns the grant both one-hot and as an index.
module rr_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter  int NUM_TX = 2,
    localparam int IW     = (NUM_TX > 1) ? $clog2(NUM_TX) : 1
) (
    input  logic [NUM_TX-1:0] req_i,
    input  logic [IW-1:0]     last_grant_i,
    output logic [NUM_TX-1:0] grant_o,
    output logic [IW-1:0]     grant_idx_o
);

    logic [IW-1:0] cand;

    // Scan from the farthest position to the nearest so the nearest valid requester wins.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        cand        = '0;
        for (int off = NUM_TX; off >= 1; off--) begin
            cand = IW'((int'(last_grant_i) + off) % NUM_TX);
            if (req_i[cand]) begin
                grant_o       = '0;
                grant_o[cand] = 1'b1;
                grant_idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/uart_stream_ctrl.sv
// Sole APB master of the UART register block: programs the divisor, shares the transmitter
// among NUM_TX byte streams round-robin, and polls the receiver into a one-entry buffer.
module uart_stream_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter  int          NUM_TX  = 2,
    parameter  logic [15:0] DIVISOR = DEFAULT_DIVISOR,
    localparam int          IW      = (NUM_TX > 1) ? $clog2(NUM_TX) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_TX-1:0]   tx_valid_i,
    input  logic [8*NUM_TX-1:0] tx_data_i,
    output logic [NUM_TX-1:0]   tx_ready_o,
    output logic                rx_valid_o,
    output logic [7:0]          rx_data_o,
    input  logic                rx_ready_i,
    input  logic                cfg_valid_i,
    input  logic [15:0]         cfg_divisor_i,
    output logic                cfg_ready_o,
    output logic                sel_receiver_o,
    output logic                sel_transmitter_o,
    output logic                sel_divisor_o,
    output logic                apb_enable_o,
    output logic                apb_write_o,
    output logic [31:0]         apb_wdata_o,
    input  logic [31:0]         apb_rdata_i
);

    ctrl_state_e       state_q;
    slot_e             slot_q;
    logic [IW-1:0]     last_grant_q;
    logic [IW-1:0]     grant_idx_q;
    logic [NUM_TX-1:0] grant_oh_q;
    logic [NUM_TX-1:0] tx_ready_q;
    logic              cfg_ready_q;
    logic              rx_valid_q;
    logic [7:0]        rx_data_q;
    logic              sel_rx_q;
    logic              sel_tx_q;
    logic              sel_div_q;
    logic              apb_enable_q;
    logic              apb_write_q;
    logic [31:0]       apb_wdata_q;

    logic [NUM_TX-1:0] arb_grant;
    logic [IW-1:0]     arb_idx;
    logic [7:0]        tx_byte;
    logic              tx_elig;
    logic              rx_elig;
    logic              take_tx;
    logic              take_rx;

    rr_arbiter #(.NUM_TX(NUM_TX)) u_arb (
        .req_i        (tx_valid_i),
        .last_grant_i (last_grant_q),
        .grant_o      (arb_grant),
        .grant_idx_o  (arb_idx)
    );

    always_comb begin
        tx_byte = '0;
        for (int i = 0; i < NUM_TX; i++) begin
            if (grant_oh_q[i]) tx_byte = tx_data_i[8*i +: 8];
        end
    end

    // The slot pointer names the preferred service; fall back to the other if it has no work.
    assign tx_elig = |tx_valid_i;
    assign rx_elig = !rx_valid_q;
    assign take_tx = tx_elig && ((slot_q == SLOT_TX) || !rx_elig);
    assign take_rx = rx_elig && !take_tx;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= INIT_S;
            slot_q       <= SLOT_RX;
            last_grant_q <= IW'(NUM_TX - 1);
            grant_idx_q  <= '0;
            grant_oh_q   <= '0;
            tx_ready_q   <= '0;
            cfg_ready_q  <= 1'b0;
            rx_valid_q   <= 1'b0;
            rx_data_q    <= '0;
            sel_rx_q     <= 1'b0;
            sel_tx_q     <= 1'b0;
            sel_div_q    <= 1'b0;
            apb_enable_q <= 1'b0;
            apb_write_q  <= 1'b0;
            apb_wdata_q  <= '0;
        end else begin
            tx_ready_q  <= '0;
            cfg_ready_q <= 1'b0;
            if (rx_valid_q && rx_ready_i) rx_valid_q <= 1'b0;

            case (state_q)
                // Reset leaves the bus idle, so INIT_S spends its first cycle raising the SETUP phase.
                INIT_S: begin
                    if (!sel_div_q) begin
                        sel_div_q   <= 1'b1;
                        apb_write_q <= 1'b1;
                        apb_wdata_q <= {16'b0, DIVISOR};
                    end else begin
                        apb_enable_q <= 1'b1;
                        state_q      <= INIT_A;
                    end
                end
                IDLE: begin
                    if (cfg_valid_i) begin
                        sel_div_q   <= 1'b1;
                        apb_write_q <= 1'b1;
                        apb_wdata_q <= {16'b0, cfg_divisor_i};
                        state_q     <= CFG_S;
                    end else if (take_tx) begin
                        sel_tx_q    <= 1'b1;
                        grant_oh_q  <= arb_grant;
                        grant_idx_q <= arb_idx;
                        slot_q      <= SLOT_RX;
                        state_q     <= TXS_S;
                    end else if (take_rx) begin
                        sel_rx_q <= 1'b1;
                        slot_q   <= SLOT_TX;
                        state_q  <= RXR_S;
                    end
                end
                CFG_S: begin
                    apb_enable_q <= 1'b1;
                    cfg_ready_q  <= 1'b1;
                    state_q      <= CFG_A;
                end
                TXS_S: begin
                    apb_enable_q <= 1'b1;
                    state_q      <= TXS_A;
                end
                TXS_A: begin
                    apb_enable_q <= 1'b0;
                    if (apb_rdata_i[UART_EMPTY_BIT]) begin
                        apb_write_q <= 1'b1;
                        apb_wdata_q <= {24'b0, tx_byte};
                        state_q     <= TXW_S;
                    end else begin
                        sel_tx_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                TXW_S: begin
                    apb_enable_q <= 1'b1;
                    tx_ready_q   <= grant_oh_q;
                    state_q      <= TXW_A;
                end
                RXR_S: begin
                    apb_enable_q <= 1'b1;
                    state_q      <= RXR_A;
                end
                RXR_A: begin
                    if (!apb_rdata_i[UART_EMPTY_BIT]) begin
                        rx_data_q  <= apb_rdata_i[7:0];
                        rx_valid_q <= 1'b1;
                    end
                    sel_rx_q     <= 1'b0;
                    apb_enable_q <= 1'b0;
                    state_q      <= IDLE;
                end
                // INIT_A, CFG_A and TXW_A all close a write access and return to IDLE.
                default: begin
                    if (state_q == TXW_A) last_grant_q <= grant_idx_q;
                    sel_rx_q     <= 1'b0;
                    sel_tx_q     <= 1'b0;
                    sel_div_q    <= 1'b0;
                    apb_enable_q <= 1'b0;
                    apb_write_q  <= 1'b0;
                    apb_wdata_q  <= '0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    assign tx_ready_o        = tx_ready_q;
    assign cfg_ready_o       = cfg_ready_q;
    assign rx_valid_o        = rx_valid_q;
    assign rx_data_o         = rx_data_q;
    assign sel_receiver_o    = sel_rx_q;
    assign sel_transmitter_o = sel_tx_q;
    assign sel_divisor_o     = sel_div_q;
    assign apb_enable_o      = apb_enable_q;
    assign apb_write_o       = apb_write_q;
    assign apb_wdata_o       = apb_wdata_q;

endmodule

// File: doc/uart_stream_ctrl.md
# uart_stream_ctrl

APB-side controller that owns the UART register block and exposes it to the rest of the SoC as byte streams. It programs the baud divisor at reset and on request. It shares the single transmitter among NUM_TX requesters with round-robin arbitration, and polls the receiver into a one-entry output buffer. It is the sole master of the UART's sel_*/apb_* inputs.

## Interface
- NUM_TX, 2: number of transmit requesters (1..8).
- DIVISOR, 16'd434: divisor written after reset.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- tx_valid  in  NUM_TX  per-requester byte valid; held until tx_ready.
- tx_data  in  8*NUM_TX  requester i byte at [8i+7:8i].
- tx_ready  out  NUM_TX  one-hot accept pulse.
- rx_valid  out  1  received byte available.
- rx_data  out  8  received byte.
- rx_ready  in  1  consumer accepts rx_data.
- cfg_valid  in  1  divisor update request; held until cfg_ready.
- cfg_divisor  in  16  new divisor.
- cfg_ready  out  1  one-cycle accept pulse.
- sel_receiver, sel_transmitter, sel_divisor  out  1 each  UART register selects.
- apb_enable, apb_write  out  1 each  APB access phase / write.
- apb_wdata  out  32  write data.
- apb_rdata  in  32  read data, valid in access phase.

## Operation
- UART register semantics:
  - transmitter read: bit31 = tx buffer empty.
  - transmitter write: [7:0] is accepted only when empty.
  - receiver read: bit31 = rx buffer empty, [7:0] = byte; every receiver access empties the UART buffer.
  - divisor write: [15:0].
- Every transfer is SETUP (one sel high, apb_enable 0) then ACCESS (same sel, apb_enable 1). No wait states.
- At most one sel is high at a time. apb_wdata and apb_write are stable across both phases.
- FSM states: INIT_S, INIT_A, IDLE, CFG_S, CFG_A, TXS_S, TXS_A, TXW_S, TXW_A, RXR_S, RXR_A.
- After reset: INIT_S/INIT_A write DIVISOR to the divisor register, then go to IDLE. cfg_ready is not pulsed for this write.
- IDLE decides the next transfer, in priority order:
  - cfg_valid: go to CFG_S; latch cfg_divisor.
  - Otherwise the slot pointer alternates RX and TX.
  - RX is eligible when the rx buffer is empty.
  - TX is eligible when any tx_valid is high.
  - Take the slot not served last if it is eligible, else the other one. If neither is eligible, stay in IDLE.
- CFG_A: pulse cfg_ready, then go to IDLE.
- TX path:
  - On entering TXS_S, latch the round-robin grant g: first valid index after last_grant, wrapping.
  - TXS_A reads the transmitter register.
  - If apb_rdata[31]=1, go to TXW_S and latch apb_wdata={24'b0, tx_data[g]}.
  - Else go to IDLE. No grant is consumed and last_grant is unchanged.
  - TXW_A: pulse tx_ready[g] and set last_grant=g, then go to IDLE.
- RX path:
  - RXR_A reads the receiver register.
  - If apb_rdata[31]=0, capture [7:0] into rx_data and set rx_valid the next cycle.
  - A receiver read is issued only when the rx buffer is empty, so no byte is ever dropped by the controller.
- rx_valid and rx_data are held until rx_valid & rx_ready. rx_valid clears the next cycle.
- The IDLE decision sees the registered rx_valid. A same-cycle pop still counts as full.

## Timing
- Reset values:
  - all sel_*, apb_enable, apb_write: 0.
  - apb_wdata: 0.
  - tx_ready, cfg_ready, rx_valid: 0; rx_data: 0.
  - last_grant: NUM_TX-1, so requester 0 wins first.
  - slot pointer: RX.
- First APB SETUP occurs in the cycle after reset deasserts.
- TX with the transmitter empty: tx_ready pulses 4 cycles after the IDLE decision cycle (IDLE, TXS_S, TXS_A, TXW_S, TXW_A).
- RX: rx_valid rises 3 cycles after the IDLE decision cycle.
- Minimum spacing between transfers is one IDLE cycle.
- Reset mid-transfer aborts it: sel and enable drop, and the divisor is rewritten on restart.
- tx_valid dropping between grant latch and TXW_S is a protocol violation; behaviour is unspecified.

## Structure
- Package uart_ctrl_pkg holds:
  - the state enum;
  - UART_EMPTY_BIT=31;
  - the slot enum;
  - DEFAULT_DIVISOR.
- Sub-module rr_arbiter(NUM_TX) takes req and last_grant and returns a one-hot grant plus its index, combinationally.

## Test plan
- Reset release -> divisor write of 434: sel_divisor SETUP, then ACCESS with apb_wdata=434. No cfg_ready pulse.
- Both requesters valid (0x41, 0x42) with the UART model empty -> tx_ready[0] then tx_ready[1]; writes 0x41, then 0x42.
- Transmitter status reports full (bit31=0) for 3 polls -> no TXW transfer and no tx_ready; the write follows the first empty read.
- UART receives 0x5A while rx_ready=0 and a second byte is pending -> rx_data=0x5A is held, no receiver reads while full, the second byte arrives after the pop.
- cfg_valid with 0x1234 during continuous TX and RX traffic -> the divisor write is the next transfer after the current one completes; cfg_ready pulses once.
- Reset asserted in TXW_S -> outputs return to reset values within 1 cycle, tx_ready never pulses, INIT write follows.
